// File: rtl/hub75_pkg.sv
// hub75_pkg: shared state type, RGB layout, address width and BCM timing helper
package hub75_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT, WAIT, LAT_A, LAT_B, LAT_C} state_e;
    typedef struct packed {
        logic b;
        logic g;
        logic r;
    } rgb_t;
    localparam int ADDR_W = 5;
    function automatic int plane_time(input int base, input int plane);
        return base << plane;
    endfunction
endpackage

// File: rtl/hub75_shifter.sv
// hub75_shifter: fetches one row-pair bit-plane column by column and drives CK/RGB
module hub75_shifter import hub75_pkg::*; #(
    parameter int COLS = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run_i,
    input  logic [2:0]                fb_rgb0_i,
    input  logic [2:0]                fb_rgb1_i,
    output logic                      fb_rd_o,
    output logic [$clog2(COLS)-1:0]   fb_col_o,
    output logic [2:0]                hub_rgb0_o,
    output logic [2:0]                hub_rgb1_o,
    output logic                      hub_ck_o,
    output logic                      done_o
);
    localparam int COL_W = $clog2(COLS);
    localparam int PH_W = $clog2(2 * CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);
    logic [COL_W-1:0] col_q, col_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic ck_q, ck_d, ph_wrap, capture;
    rgb_t rgb0_q, rgb0_d, rgb1_q, rgb1_d;
    // counters wrap to zero at the end of a shift so the next one starts at column 0 phase 0
    always_comb begin
        ph_wrap = ph_q == PH_LAST;
        capture = run_i && ph_q == PH_W'(1);
        ph_d = run_i ? (ph_wrap ? '0 : ph_q + 1'b1) : ph_q;
        col_d = run_i && ph_wrap ? col_q + 1'b1 : col_q;
        ck_d = run_i && ph_q == PH_RISE ? 1'b1 : (ph_wrap ? 1'b0 : ck_q);
        rgb0_d = capture ? rgb_t'(fb_rgb0_i) : rgb0_q;
        rgb1_d = capture ? rgb_t'(fb_rgb1_i) : rgb1_q;
    end
    // shift datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
            ph_q <= '0;
            ck_q <= 1'b0;
            rgb0_q <= '0;
            rgb1_q <= '0;
        end else begin
            col_q <= col_d;
            ph_q <= ph_d;
            ck_q <= ck_d;
            rgb0_q <= rgb0_d;
            rgb1_q <= rgb1_d;
        end
    end
    assign fb_rd_o = run_i && ph_q == '0;
    assign fb_col_o = col_q;
    assign hub_rgb0_o = rgb0_q;
    assign hub_rgb1_o = rgb1_q;
    assign hub_ck_o = ck_q;
    assign done_o = run_i && ph_wrap && (&col_q);
endmodule

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: HUB75 1/16-scan BCM sequencer (shift, display timing, latch and blank)
module hub75_scan_ctrl import hub75_pkg::*; #(
    parameter int COLS = 32,
    parameter int ROWS = 16,
    parameter int PLANES = 4,
    parameter int CLK_DIV = 2,
    parameter int BASE_TIME = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable_i,
    output logic                        fb_rd_o,
    output logic [$clog2(ROWS)-1:0]     fb_row_o,
    output logic [$clog2(COLS)-1:0]     fb_col_o,
    output logic [$clog2(PLANES)-1:0]   fb_plane_o,
    input  logic [2:0]                  fb_rgb0_i,
    input  logic [2:0]                  fb_rgb1_i,
    output logic [2:0]                  hub_rgb0_o,
    output logic [2:0]                  hub_rgb1_o,
    output logic                        hub_ck_o,
    output logic                        hub_la_o,
    output logic                        hub_bl_o,
    output logic [ADDR_W-1:0]           hub_addr_o,
    output logic                        frame_start_o,
    output logic                        busy_o
);
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(PLANES);
    localparam int TW = $clog2((BASE_TIME << (PLANES - 1)) + 1);
    state_e state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] plane_q, plane_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic bl_q, la_q, fs_q, fs_d, shift_done, last_plane;
    hub75_shifter #(.COLS(COLS), .CLK_DIV(CLK_DIV)) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (state_q == SHIFT),
        .fb_rgb0_i  (fb_rgb0_i),
        .fb_rgb1_i  (fb_rgb1_i),
        .fb_rd_o    (fb_rd_o),
        .fb_col_o   (fb_col_o),
        .hub_rgb0_o (hub_rgb0_o),
        .hub_rgb1_o (hub_rgb1_o),
        .hub_ck_o   (hub_ck_o),
        .done_o     (shift_done)
    );
    // sequencing FSM; the display timer free-runs down to zero in every state
    always_comb begin
        state_d = state_q;
        row_d = row_q;
        plane_d = plane_q;
        addr_d = addr_q;
        fs_d = 1'b0;
        last_plane = plane_q == PW'(PLANES - 1);
        timer_d = timer_q != '0 ? timer_q - 1'b1 : timer_q;
        case (state_q)
            IDLE: begin
                state_d = enable_i ? SHIFT : IDLE;
                row_d = enable_i ? '0 : row_q;
                plane_d = enable_i ? '0 : plane_q;
            end
            SHIFT: state_d = shift_done ? WAIT : SHIFT;
            WAIT: state_d = timer_q == '0 ? LAT_A : WAIT;
            LAT_A: begin
                state_d = LAT_B;
                addr_d = ADDR_W'(row_q);
            end
            LAT_B: state_d = LAT_C;
            LAT_C: begin
                state_d = enable_i ? SHIFT : IDLE;
                timer_d = enable_i ? TW'(plane_time(BASE_TIME, 32'(plane_q))) : '0;
                fs_d = row_q == '0 && plane_q == '0;
                plane_d = last_plane ? '0 : plane_q + 1'b1;
                row_d = last_plane ? row_q + 1'b1 : row_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // state, pointer and registered panel controls; blank follows the timer so BL-low time is exact
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q <= '0;
            plane_q <= '0;
            addr_q <= '0;
            timer_q <= '0;
            bl_q <= 1'b1;
            la_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q <= row_d;
            plane_q <= plane_d;
            addr_q <= addr_d;
            timer_q <= timer_d;
            bl_q <= timer_d == '0;
            la_q <= state_d == LAT_B;
            fs_q <= fs_d;
        end
    end
    assign fb_row_o = row_q;
    assign fb_plane_o = plane_q;
    assign hub_addr_o = addr_q;
    assign hub_la_o = la_q;
    assign hub_bl_o = bl_q;
    assign frame_start_o = fs_q;
    assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb_hub75_scan_ctrl: directed checks of shift timing, BCM blanking, latch order, wrap, stop and reset
module tb_hub75_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    logic fb_rd, hub_ck, hub_la, hub_bl, frame_start, busy;
    logic [3:0] fb_row;
    logic [4:0] fb_col, hub_addr;
    logic [1:0] fb_plane;
    logic [2:0] fb_rgb0 = 3'd0, fb_rgb1 = 3'd0, hub_rgb0, hub_rgb1;

    logic fb_rd8, ck8, la8, bl8, fs8, busy8;
    logic [3:0] fb_row8;
    logic [4:0] fb_col8, addr8;
    logic [1:0] fb_plane8;
    logic [2:0] rgb0_8, rgb1_8;

    hub75_scan_ctrl #(.BASE_TIME(64)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable),
        .fb_rd_o(fb_rd), .fb_row_o(fb_row), .fb_col_o(fb_col), .fb_plane_o(fb_plane),
        .fb_rgb0_i(fb_rgb0), .fb_rgb1_i(fb_rgb1),
        .hub_rgb0_o(hub_rgb0), .hub_rgb1_o(hub_rgb1), .hub_ck_o(hub_ck), .hub_la_o(hub_la),
        .hub_bl_o(hub_bl), .hub_addr_o(hub_addr), .frame_start_o(frame_start), .busy_o(busy)
    );

    hub75_scan_ctrl #(.BASE_TIME(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable),
        .fb_rd_o(fb_rd8), .fb_row_o(fb_row8), .fb_col_o(fb_col8), .fb_plane_o(fb_plane8),
        .fb_rgb0_i(3'd0), .fb_rgb1_i(3'd0),
        .hub_rgb0_o(rgb0_8), .hub_rgb1_o(rgb1_8), .hub_ck_o(ck8), .hub_la_o(la8),
        .hub_bl_o(bl8), .hub_addr_o(addr8), .frame_start_o(fs8), .busy_o(busy8)
    );

    int total = 0;
    int bad = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] pat(input int r, input int c, input int p);
        return 3'(c + 3 * r + 5 * p);
    endfunction

    // framebuffer model: data valid exactly one cycle after the read strobe, zero otherwise
    always @(posedge clk) begin
        fb_rgb0 <= fb_rd ? pat(int'(fb_row), int'(fb_col), int'(fb_plane)) : 3'd0;
        fb_rgb1 <= fb_rd ? pat(int'(fb_row), int'(fb_col), int'(fb_plane)) ^ 3'b101 : 3'd0;
    end

    logic mon = 1'b0;
    int ck_cnt, ck_gap, latches = 0, frames = 0, low_cnt;
    logic prev_ck, prev_bl, prev_la, prev_fs;
    // main-instance observer: CK spacing/data, latch order, pulse widths, BL-low run lengths
    always @(negedge clk) begin
        if (!mon) begin
            ck_cnt = 0;
            ck_gap = 0;
            low_cnt = 0;
        end else begin
            ck_gap++;
            if (hub_ck && !prev_ck) begin
                if (ck_cnt > 0) chk("ck_period", ck_gap, 4);
                chk("rgb0", hub_rgb0, pat(int'(fb_row), ck_cnt, int'(fb_plane)));
                chk("rgb1", hub_rgb1, pat(int'(fb_row), ck_cnt, int'(fb_plane)) ^ 3'b101);
                ck_cnt++;
                ck_gap = 0;
            end
            if (prev_la) chk("la_pulse", hub_la, 0);
            if (prev_fs) chk("fs_pulse", frame_start, 0);
            if (hub_la) begin
                chk("la_bl", hub_bl, 1);
                chk("la_ck_edges", ck_cnt, 32);
                chk("la_addr", hub_addr, (latches / 4) % 16);
                chk("la_row", fb_row, (latches / 4) % 16);
                chk("la_plane", fb_plane, latches % 4);
                latches++;
                ck_cnt = 0;
            end
            if (frame_start) begin
                chk("fs_index", (latches - 1) % 64, 0);
                frames++;
            end
            if (!hub_bl) low_cnt++;
            else if (!prev_bl) begin
                chk("bl_low_run", low_cnt, 64 << ((latches - 1) % 4));
                low_cnt = 0;
            end
        end
        prev_ck = hub_ck;
        prev_bl = hub_bl;
        prev_la = hub_la;
        prev_fs = frame_start;
    end

    int runs8[$];
    int gaps8[$];
    int low8 = 0, high8 = 0;
    logic prev_bl8 = 1'b1;
    // BASE_TIME=8 observer: records BL-low runs and the BL-high gaps between them
    always @(negedge clk) begin
        if (mon) begin
            if (!bl8) begin
                if (prev_bl8 && runs8.size() > 0) gaps8.push_back(high8);
                low8++;
                high8 = 0;
            end else begin
                if (!prev_bl8) begin
                    runs8.push_back(low8);
                    low8 = 0;
                end
                high8++;
            end
        end
        prev_bl8 = bl8;
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_bl", hub_bl, 1);
        chk("rst_ck", hub_ck, 0);
        chk("rst_la", hub_la, 0);
        chk("rst_addr", hub_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd", fb_rd, 0);
        chk("rst_fs", frame_start, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_bl", hub_bl, 1);
        chk("idle_busy", busy, 0);
        chk("idle_rd", fb_rd, 0);
        enable = 1'b1;
        mon = 1'b1;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_rd", fb_rd, 1);
        for (int i = 0; i < 40000 && latches < 84; i++) @(negedge clk);
        chk("latches_84", latches, 84);
        chk("frames", frames, 2);
        chk("lsb8_run", runs8.size() > 0 ? runs8[0] : -1, 8);
        chk("lsb8_gap", gaps8.size() > 0 ? gaps8[0] : -1, 124);
        chk("p1_8_run", runs8.size() > 1 ? runs8[1] : -1, 16);
        repeat (40) @(negedge clk);
        chk("midshift_row", fb_row, 5);
        enable = 1'b0;
        for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
        chk("stop_busy", busy, 0);
        chk("stop_addr", hub_addr, 5);
        chk("stop_latches", latches, 85);
        chk("stop_bl", hub_bl, 1);
        chk("stop_row", fb_row, 5);
        chk("stop_plane", fb_plane, 1);
        repeat (20) @(negedge clk);
        chk("hold_bl", hub_bl, 1);
        chk("hold_busy", busy, 0);
        mon = 1'b0;
        enable = 1'b1;
        repeat (30) @(negedge clk);
        chk("restart_row", fb_row, 0);
        chk("restart_plane", fb_plane, 0);
        chk("restart_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_bl", hub_bl, 1);
        chk("mrst_ck", hub_ck, 0);
        chk("mrst_la", hub_la, 0);
        chk("mrst_addr", hub_addr, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_rd", fb_rd, 0);
        chk("mrst_col", fb_col, 0);
        chk("mrst_rgb0", hub_rgb0, 0);
        chk("mrst_rgb1", hub_rgb1, 0);
        chk("mrst_fs", frame_start, 0);
        rst_n = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
